inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter and drives a req/ack handshake to instruction memory. It delivers each fetched pc/instruction pair on o_if_pc/o_if_inst for the IF/ID register to capture, and raises a stall request to pipeline control while memory is pending. It also applies branch redirects from decode and flush redirects from control.

Parameters:
ADDR_W, 32, instruction address width (matches N_INST_ADDR)
DATA_W, 32, instruction word width (matches N_INST_DATA)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
i_clk  input  1  clock
i_rst_n  input  1  synchronous active-low reset
i_stall  input  6  pipeline stall vector from ctrl; bit0 = PC stage, bit1 = IF stage (STOP=1)
i_flush  input  1  exception/eret flush from ctrl
i_new_pc  input  ADDR_W  redirect target accompanying i_flush
i_branch_flag  input  1  taken branch/jump resolved in decode
i_branch_target  input  ADDR_W  branch/jump target
o_imem_req  output  1  fetch request valid
o_imem_addr  output  ADDR_W  fetch address
i_imem_ack  input  1  memory accepted request and returns data this cycle
i_imem_rdata  input  DATA_W  instruction word, valid with i_imem_ack
o_if_pc  output  ADDR_W  pc of the delivered instruction, to IF/ID
o_if_inst  output  DATA_W  delivered instruction, to IF/ID; 0 = nop
o_stallreq  output  1  fetch stall request to ctrl

Behaviour:
- Interface fixed: single clock i_clk; reset i_rst_n is synchronous and active-low, sampled only on posedge i_clk.
- Reset state: state=S_IDLE, pc=RESET_PC, o_imem_req=0, o_imem_addr=RESET_PC, o_if_pc=0, o_if_inst=0, o_stallreq=0.
- FSM states: S_IDLE, S_REQ, S_HOLD, S_DISCARD.
- S_IDLE: entered only via reset; moves to S_REQ on the first clock with i_rst_n=1.
- S_REQ: o_imem_req=1 and o_imem_addr=pc.
  - On i_imem_ack with i_stall[1]=NO_STOP: register o_if_pc=pc and o_if_inst=i_imem_rdata, advance pc, stay in S_REQ. Throughput is 1 instruction/cycle with a zero-wait memory.
  - On i_imem_ack with i_stall[1]=STOP: latch rdata/pc into the hold buffer, go to S_HOLD, deassert req.
- S_HOLD: o_imem_req=0. When i_stall[1] returns to NO_STOP, drive the buffered pair, advance pc, go to S_REQ.
- o_stallreq = (state==S_REQ) && !i_imem_ack. It is combinational and is 0 in every other state.
- Next-pc priority: flush > i_stall[0]==STOP (pc held) > i_branch_flag (pc=i_branch_target) > pc+4.
- pc+4 wraps modulo 2^ADDR_W: 32'hFFFF_FFFC -> 32'h0000_0000.
- Branch while i_stall[0]=STOP: the redirect is not lost. Target is latched in a pending register and applied on the first unstalled advance.
- Flush (any state):
  - pc=i_new_pc; o_if_inst=0 and o_if_pc=0 next cycle; hold buffer and pending branch cleared.
  - If flush arrives in S_REQ with no ack that cycle, go to S_DISCARD: req stays 1 on the old address until ack, then the data is dropped and the FSM moves to S_REQ at the new pc.
  - Flush coincident with ack: data dropped, S_REQ at i_new_pc next cycle.
- Reset mid-request: FSM returns to S_IDLE immediately. The memory side tolerates a request withdrawn without ack.
- o_if_pc/o_if_inst change only on a delivery or a flush; otherwise they hold.

Optional Feature:
INST_FETCH_ALIGN_CHECK_EN
- Defined: adds output o_excp_adel (1 bit, reset 0). If pc[1:0]!=0 in S_REQ, no memory request is issued. The block delivers o_if_inst=0 with o_if_pc=pc and pulses o_excp_adel for one cycle, then waits in S_HOLD for flush.
- Undefined: port absent, pc[1:0] ignored, and o_imem_addr is forced to {pc[ADDR_W-1:2],2'b00}.

Decomposition:
- Shared package/defines.svh: STOP/NO_STOP, RST_ENABLE, INST_NOP (32'h0), typedef enum logic[1:0] if_state_e {S_IDLE,S_REQ,S_HOLD,S_DISCARD}, PC_INCR=4.
- One sub-module: if_pc_next, a combinational next-pc priority mux (flush, stall, branch, pending branch, sequential).

Test Plan:
- Reset release, ack tied 1 -> req rises cycle 1 at 0x0; o_if_pc sequence 0x0,0x4,0x8 on consecutive cycles; stallreq stays 0.
- Ack delayed 3 cycles at pc 0x10 -> req and addr 0x10 held, stallreq=1 for 3 cycles, then o_if_inst=rdata, o_if_pc=0x10.
- i_stall=6'b000011 on the ack cycle for 0x20, released 2 cycles later -> S_HOLD, req=0; afterwards o_if_pc=0x20 with correct inst, next addr 0x24.
- Branch to 0x100 while i_stall[0]=1 for 2 cycles -> pc held; first unstalled fetch addr=0x100, no 0x+4 fetch leaks.
- Flush to 0x180 while a request is pending (no ack) -> S_DISCARD; stale ack data never appears; o_if_inst=0, then the first fetch is at 0x180.
- pc=0xFFFF_FFFC fetched -> next addr 0x0000_0000; reset asserted mid-request -> req=0 and all outputs at reset values next cycle.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and its helpers.
package inst_fetch_pkg;

    localparam logic        STOP       = 1'b1;
    localparam logic        NO_STOP    = 1'b0;
    localparam logic        RST_ENABLE = 1'b0;
    localparam logic [31:0] INST_NOP   = 32'h0000_0000;
    localparam int          PC_INCR    = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQ     = 2'b01,
        S_HOLD    = 2'b10,
        S_DISCARD = 2'b11
    } if_state_e;

endpackage

// File: rtl/inst_fetch_if_pc_next.sv
// Next-pc priority mux: flush, pc stall, live branch, pending branch, sequential.
module if_pc_next
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              stall_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              pend_valid,
    input  logic [ADDR_W-1:0] pend_target,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
);

    always_comb begin
        if (flush) begin
            pc_next = new_pc;
        end else if (stall_pc == STOP) begin
            pc_next = pc;
        end else if (branch_flag) begin
            pc_next = branch_target;
        end else if (pend_valid) begin
            pc_next = pend_target;
        end else begin
            // Sequential advance wraps naturally at the top of the address space.
            pc_next = pc + ADDR_W'(PC_INCR);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the pc and runs the req/ack handshake to instruction memory.
// Optional misaligned-pc trap is built when INST_FETCH_ALIGN_CHECK_EN is defined.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [5:0]        i_stall,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_new_pc,
    input  logic              i_branch_flag,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic [ADDR_W-1:0] o_if_pc,
    output logic [DATA_W-1:0] o_if_inst,
`ifdef INST_FETCH_ALIGN_CHECK_EN
    output logic              o_excp_adel,
`endif
    output logic              o_stallreq
);

    if_state_e         state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] hold_pc;
    logic [DATA_W-1:0] hold_inst;
    logic [ADDR_W-1:0] pend_target;
    logic              pend_valid;
    logic              adel_wait;
    logic              stall_pc;
    logic              stall_if;
    logic              advance;
    logic              pc_ok;
    logic              pc_ok_d;
    logic              unused_stall;

    assign stall_pc     = i_stall[0];
    assign stall_if     = i_stall[1];
    assign unused_stall = ^i_stall[5:2];

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign pc_ok   = (pc[1:0] == 2'b00);
    assign pc_ok_d = (pc_d[1:0] == 2'b00);
    assign addr_d  = pc_d;
`else
    assign pc_ok   = 1'b1;
    assign pc_ok_d = 1'b1;
    assign addr_d  = {pc_d[ADDR_W-1:2], 2'b00};
`endif

    // An advance is any cycle that hands an instruction to IF/ID.
    assign advance = ((state == S_REQ) && i_imem_ack && (stall_if == NO_STOP) && pc_ok) ||
                     ((state == S_HOLD) && (stall_if == NO_STOP) && !adel_wait);

    assign pc_d = (i_flush || advance) ? pc_next : pc;

    assign o_stallreq = (state == S_REQ) && !i_imem_ack && pc_ok;

    if_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .flush         (i_flush),
        .new_pc        (i_new_pc),
        .stall_pc      (stall_pc),
        .branch_flag   (i_branch_flag),
        .branch_target (i_branch_target),
        .pend_valid    (pend_valid),
        .pend_target   (pend_target),
        .pc            (pc),
        .pc_next       (pc_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst_n == RST_ENABLE) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            o_imem_req  <= 1'b0;
            o_imem_addr <= RESET_PC;
            o_if_pc     <= '0;
            o_if_inst   <= DATA_W'(INST_NOP);
            hold_pc     <= '0;
            hold_inst   <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            adel_wait   <= 1'b0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            o_excp_adel <= 1'b0;
`endif
        end else begin
            pc <= pc_d;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            o_excp_adel <= 1'b0;
`endif
            // A branch that cannot be taken this cycle is parked until the next unstalled advance.
            if (i_flush || (advance && stall_pc == NO_STOP)) begin
                pend_valid <= 1'b0;
            end else if (i_branch_flag) begin
                pend_valid  <= 1'b1;
                pend_target <= i_branch_target;
            end

            if (i_flush) begin
                o_if_pc   <= '0;
                o_if_inst <= DATA_W'(INST_NOP);
                hold_pc   <= '0;
                hold_inst <= '0;
                adel_wait <= 1'b0;
                // An outstanding request cannot be withdrawn; its data is dropped when it lands.
                if ((state == S_REQ || state == S_DISCARD) && o_imem_req && !i_imem_ack) begin
                    state <= S_DISCARD;
                end else begin
                    state       <= S_REQ;
                    o_imem_req  <= pc_ok_d;
                    o_imem_addr <= addr_d;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        state       <= S_REQ;
                        o_imem_req  <= pc_ok_d;
                        o_imem_addr <= addr_d;
                    end
                    S_REQ: begin
`ifdef INST_FETCH_ALIGN_CHECK_EN
                        if (!pc_ok) begin
                            o_if_pc     <= pc;
                            o_if_inst   <= DATA_W'(INST_NOP);
                            o_excp_adel <= 1'b1;
                            adel_wait   <= 1'b1;
                            o_imem_req  <= 1'b0;
                            state       <= S_HOLD;
                        end else
`endif
                        if (i_imem_ack) begin
                            if (stall_if == NO_STOP) begin
                                o_if_pc     <= pc;
                                o_if_inst   <= i_imem_rdata;
                                o_imem_req  <= pc_ok_d;
                                o_imem_addr <= addr_d;
                            end else begin
                                hold_pc    <= pc;
                                hold_inst  <= i_imem_rdata;
                                o_imem_req <= 1'b0;
                                state      <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!adel_wait && stall_if == NO_STOP) begin
                            o_if_pc     <= hold_pc;
                            o_if_inst   <= hold_inst;
                            o_imem_req  <= pc_ok_d;
                            o_imem_addr <= addr_d;
                            state       <= S_REQ;
                        end
                    end
                    S_DISCARD: begin
                        if (i_imem_ack) begin
                            o_imem_req  <= pc_ok_d;
                            o_imem_addr <= addr_d;
                            state       <= S_REQ;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic against a bus-level model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        bflag;
    logic [31:0] btarget;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq;

    int errors = 0;
    int checks = 0;

    // Reference model: what is on the memory bus, what is parked, and what IF/ID should see.
    logic        m_alive;
    logic        m_open;
    logic        m_discard;
    logic        m_parked;
    logic        m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_park_pc;
    logic [31:0] m_park_inst;
    logic [31:0] m_pend_t;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_inst;

    always #5 clk = ~clk;

    inst_fetch dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_new_pc        (new_pc),
        .i_branch_flag   (bflag),
        .i_branch_target (btarget),
        .o_imem_req      (req),
        .o_imem_addr     (addr),
        .i_imem_ack      (ack),
        .i_imem_rdata    (rdata),
        .o_if_pc         (if_pc),
        .o_if_inst       (if_inst),
        .o_stallreq      (stallreq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] wordAddr(input logic [31:0] p);
        return {p[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] instOf(input logic [31:0] p);
        return p ^ 32'h5A5A_0000;
    endfunction

    // An instruction reaches IF/ID; the pc moves on unless the pc stage is stopped.
    task automatic modelDeliver(input logic [31:0] p, input logic [31:0] d, output logic consumed);
        m_if_pc   = p;
        m_if_inst = d;
        consumed  = !stall[0];
        if (!stall[0]) begin
            if (bflag)       m_pc = btarget;
            else if (m_pend) m_pc = m_pend_t;
            else             m_pc = m_pc + 32'd4;
            m_pend = 1'b0;
        end
        m_open = 1'b1;
        m_addr = wordAddr(m_pc);
    endtask

    task automatic modelStep();
        logic consumed;
        consumed = 1'b0;
        if (!rst_n) begin
            m_alive = 0; m_open = 0; m_discard = 0; m_parked = 0; m_pend = 0;
            m_pc = 32'h0; m_addr = 32'h0; m_park_pc = 0; m_park_inst = 0; m_pend_t = 0;
            m_if_pc = 32'h0; m_if_inst = 32'h0;
            return;
        end
        if (flush) begin
            m_if_pc = 0; m_if_inst = 0; m_parked = 0; m_pend = 0;
            m_pc = new_pc; m_alive = 1'b1;
            if (m_open && !ack) begin
                m_discard = 1'b1;
            end else begin
                m_discard = 1'b0;
                m_open    = 1'b1;
                m_addr    = wordAddr(new_pc);
            end
            return;
        end
        if (!m_alive) begin
            m_alive = 1'b1;
            m_open  = 1'b1;
            m_addr  = wordAddr(m_pc);
        end else if (m_open && ack && m_discard) begin
            m_discard = 1'b0;
            m_addr    = wordAddr(m_pc);
        end else if (m_open && ack && stall[1]) begin
            m_parked    = 1'b1;
            m_park_pc   = m_pc;
            m_park_inst = rdata;
            m_open      = 1'b0;
        end else if (m_open && ack) begin
            modelDeliver(m_pc, rdata, consumed);
        end else if (m_parked && !stall[1]) begin
            m_parked = 1'b0;
            modelDeliver(m_park_pc, m_park_inst, consumed);
        end
        if (bflag && !consumed) begin
            m_pend   = 1'b1;
            m_pend_t = btarget;
        end
    endtask

    // Drive one cycle of inputs, check the combinational stall request, then the registered outputs.
    task automatic applyStimulus(input logic r, input logic [5:0] s, input logic f, input logic [31:0] np,
                                 input logic b, input logic [31:0] bt, input logic a, input logic [31:0] d);
        rst_n = r; stall = s; flush = f; new_pc = np; bflag = b; btarget = bt; ack = a; rdata = d;
        #1;
        checkOutput("stallreq", 32'(stallreq), 32'(m_open && !m_discard && !a));
        modelStep();
        @(negedge clk);
        checkOutput("imem_req", 32'(req), 32'(m_open));
        checkOutput("imem_addr", addr, m_addr);
        checkOutput("if_pc", if_pc, m_if_pc);
        checkOutput("if_inst", if_inst, m_if_inst);
    endtask

    task automatic fetchOne(input logic [31:0] p);
        applyStimulus(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, instOf(p));
    endtask

    task automatic idleCycle(input logic [5:0] s);
        applyStimulus(1'b1, s, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0; new_pc = 0; bflag = 0; btarget = 0; ack = 0; rdata = 0;
        modelStep();
        @(negedge clk);
        applyStimulus(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("rst_req", 32'(req), 32'd0);
        checkOutput("rst_addr", addr, 32'h0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_inst", if_inst, 32'h0);

        $display("[TB] reset release and back-to-back fetch");
        idleCycle(6'b0);
        checkOutput("first_req", 32'(req), 32'd1);
        checkOutput("first_addr", addr, 32'h0);
        for (int k = 0; k < 4; k++) begin
            fetchOne(32'(k * 4));
            checkOutput("seq_if_pc", if_pc, 32'(k * 4));
        end

        $display("[TB] delayed ack at 0x10");
        for (int k = 0; k < 3; k++) begin
            idleCycle(6'b0);
            checkOutput("wait_addr", addr, 32'h10);
            checkOutput("wait_stallreq", 32'(stallreq), 32'd1);
        end
        applyStimulus(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0010);
        checkOutput("late_if_pc", if_pc, 32'h10);
        checkOutput("late_if_inst", if_inst, 32'hCAFE_0010);
        fetchOne(32'h14); fetchOne(32'h18); fetchOne(32'h1C);

        $display("[TB] IF stall on ack at 0x20");
        applyStimulus(1'b1, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBEEF_0020);
        checkOutput("hold_req", 32'(req), 32'd0);
        checkOutput("hold_if_pc", if_pc, 32'h1C);
        idleCycle(6'b000011);
        idleCycle(6'b0);
        checkOutput("release_if_pc", if_pc, 32'h20);
        checkOutput("release_if_inst", if_inst, 32'hBEEF_0020);
        checkOutput("release_addr", addr, 32'h24);

        $display("[TB] branch under pc stall");
        applyStimulus(1'b1, 6'b000011, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0);
        idleCycle(6'b000011);
        checkOutput("stalled_addr", addr, 32'h24);
        fetchOne(32'h24);
        checkOutput("branch_addr", addr, 32'h100);
        fetchOne(32'h100);
        checkOutput("branch_if_pc", if_pc, 32'h100);

        $display("[TB] flush with request in flight");
        applyStimulus(1'b1, 6'b0, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("flush_if_inst", if_inst, 32'h0);
        checkOutput("discard_addr", addr, 32'h104);
        idleCycle(6'b0);
        checkOutput("discard_stallreq", 32'(stallreq), 32'd0);
        applyStimulus(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_DEAD);
        checkOutput("dropped_if_inst", if_inst, 32'h0);
        checkOutput("redirect_addr", addr, 32'h180);
        fetchOne(32'h180);
        checkOutput("redirect_if_pc", if_pc, 32'h180);

        $display("[TB] pc wrap and reset mid-request");
        applyStimulus(1'b1, 6'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("wrap_start_addr", addr, 32'hFFFF_FFF8);
        fetchOne(32'hFFFF_FFF8);
        fetchOne(32'hFFFF_FFFC);
        checkOutput("wrap_addr", addr, 32'h0);
        checkOutput("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        idleCycle(6'b0);
        applyStimulus(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("midrst_req", 32'(req), 32'd0);
        checkOutput("midrst_if_pc", if_pc, 32'h0);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        r;
            logic [5:0]  s;
            logic        f;
            logic        b;
            logic        a;
            logic [31:0] np;
            logic [31:0] bt;
            r = ($urandom_range(0, 399) != 0);
            case ($urandom_range(0, 9))
                0, 1:    s = 6'b000011;
                2:       s = 6'b000001;
                3:       s = 6'b000010;
                4:       s = 6'b111111;
                default: s = 6'b000000;
            endcase
            f  = ($urandom_range(0, 29) == 0);
            b  = ($urandom_range(0, 11) == 0);
            a  = m_open && ($urandom_range(0, 3) != 0);
            np = $urandom & 32'hFFFF_FFFC;
            bt = $urandom & 32'hFFFF_FFFC;
            applyStimulus(r, s, f, np, b, bt, a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
